// File: rtl/m92_sound_latch_if.sv
// Main-CPU / sound-CPU side signals of the M92 sound mailbox.
// The slave modport is the mailbox itself; the master modport is whoever drives the CPU strobes.
interface m92_sound_latch_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic            ce_cycle;
    logic            main_wr;
    logic [7:0]      main_din;
    logic            main_full;
    logic            main_ovf;
    logic            main_ovf_clr;
    logic            main_rd;
    logic [7:0]      main_reply;
    logic            main_irq;
    logic            snd_rd;
    logic [7:0]      snd_cmd;
    logic [CntW-1:0] snd_count;
    logic            snd_wr;
    logic [7:0]      snd_din;
    logic            intp;

    modport slave (
        input  ce_cycle, main_wr, main_din, main_ovf_clr, main_rd, snd_rd, snd_wr, snd_din,
        output main_full, main_ovf, main_reply, main_irq, snd_cmd, snd_count, intp
    );

    modport master (
        output ce_cycle, main_wr, main_din, main_ovf_clr, main_rd, snd_rd, snd_wr, snd_din,
        input  main_full, main_ovf, main_reply, main_irq, snd_cmd, snd_count, intp
    );
endinterface

// File: rtl/m92_sound_latch.sv
// M92 main-CPU -> V35 command FIFO with per-command INTP0 edge generation,
// plus a one-byte reply latch back to the main CPU.
module m92_sound_latch #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned IRQ_GAP    = 4,
    parameter bit          IRQ_ACTLOW = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    m92_sound_latch_if.slave   bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned GapW = $clog2(IRQ_GAP + 1);

    localparam bit IntpIdle = IRQ_ACTLOW;
    localparam bit IntpAct  = ~IRQ_ACTLOW;

    typedef enum logic [1:0] {StIdle, StAssert, StGap} irq_state_e;

    // Command FIFO state
    logic [7:0]      mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            full_q, full_d;
    logic            ovf_q, ovf_d;

    // Reply latch state
    logic [7:0]      reply_q, reply_d;
    logic            irq_q, irq_d;

    // Interrupt sequencer state
    irq_state_e      state_q;
    logic [GapW-1:0] gap_cnt_q;
    logic            intp_q;

    logic empty;
    logic pop_ok;
    logic push_ok;

    assign empty   = (count_q == '0);
    assign pop_ok  = bus.snd_rd && !empty;
    // A full FIFO still takes a push when a pop frees the head in the same clk.
    assign push_ok = bus.main_wr && (!full_q || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        full_d = (count_d == CntW'(DEPTH));

        // Set beats clear when a dropped push coincides with the clear strobe.
        if (bus.main_ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (bus.main_wr && !push_ok) begin
            ovf_d = 1'b1;
        end
    end

    always_comb begin
        reply_d = reply_q;
        irq_d   = irq_q;
        if (bus.snd_wr) begin
            reply_d = bus.snd_din;
            irq_d   = 1'b1;
        end else if (bus.main_rd) begin
            irq_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= bus.main_din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            reply_q  <= 8'h00;
            irq_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
            reply_q  <= reply_d;
            irq_q    <= irq_d;
        end
    end

    // One active period per command; the gap guarantees the V35 sees a fresh edge each time.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            gap_cnt_q <= '0;
            intp_q    <= IntpIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!empty) begin
                        state_q <= StAssert;
                        intp_q  <= IntpAct;
                    end
                end
                StAssert: begin
                    if (pop_ok) begin
                        state_q   <= StGap;
                        gap_cnt_q <= GapW'(IRQ_GAP);
                        intp_q    <= IntpIdle;
                    end
                end
                StGap: begin
                    if (gap_cnt_q == '0) begin
                        state_q <= StIdle;
                    end else if (bus.ce_cycle) begin
                        gap_cnt_q <= gap_cnt_q - GapW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    intp_q  <= IntpIdle;
                end
            endcase
        end
    end

    assign bus.snd_cmd    = empty ? 8'hFF : mem_q[rd_ptr_q];
    assign bus.snd_count  = count_q;
    assign bus.main_full  = full_q;
    assign bus.main_ovf   = ovf_q;
    assign bus.main_reply = reply_q;
    assign bus.main_irq   = irq_q;
    assign bus.intp       = intp_q;
endmodule

// File: tb/tb_m92_sound_latch.sv
// Directed bench for m92_sound_latch: the driver queues expectations, a negedge monitor
// compares them, checks every sound-side pop against its expected byte and tracks intp periods.
module tb_m92_sound_latch;
    localparam int unsigned DEPTH      = 4;
    localparam int unsigned IRQ_GAP    = 4;
    localparam bit          IRQ_ACTLOW = 1'b1;
    localparam bit          ACT        = ~IRQ_ACTLOW;

    localparam int SelCount = 0;
    localparam int SelCmd   = 1;
    localparam int SelFull  = 2;
    localparam int SelOvf   = 3;
    localparam int SelReply = 4;
    localparam int SelIrq   = 5;
    localparam int SelIntp  = 6;

    typedef struct {
        string      name;
        int         sel;
        logic [7:0] exp;
    } chk_t;

    logic clk;
    logic reset;

    m92_sound_latch_if #(.DEPTH(DEPTH)) bus ();

    m92_sound_latch #(
        .DEPTH     (DEPTH),
        .IRQ_GAP   (IRQ_GAP),
        .IRQ_ACTLOW(IRQ_ACTLOW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int         vectors;
    int         miscompares;
    chk_t       chk_q[$];
    logic [7:0] exp_pop_q[$];
    int         periods;
    int         gap_log[$];
    int         gap_ticks;
    bit         prev_act;
    bit         seen_act;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ce_cycle ticks every other clk.
    initial begin
        bus.ce_cycle = 1'b0;
        forever begin
            @(posedge clk);
            #1 bus.ce_cycle = ~bus.ce_cycle;
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: condition not reached", name);
    endtask

    function automatic logic [7:0] sig_val(input int sel);
        case (sel)
            SelCount: return 8'(bus.snd_count);
            SelCmd:   return bus.snd_cmd;
            SelFull:  return 8'(bus.main_full);
            SelOvf:   return 8'(bus.main_ovf);
            SelReply: return bus.main_reply;
            SelIrq:   return 8'(bus.main_irq);
            default:  return 8'(bus.intp);
        endcase
    endfunction

    always @(negedge clk) begin
        chk_t c;
        logic [7:0] e;
        bit act;
        while (chk_q.size() != 0) begin
            c = chk_q.pop_front();
            check(c.name, sig_val(c.sel), c.exp);
        end
        if (bus.snd_rd) begin
            if (exp_pop_q.size() == 0) begin
                fail_now("pop_unexpected");
            end else begin
                e = exp_pop_q.pop_front();
                check("pop_data", bus.snd_cmd, e);
            end
        end
        act = (bus.intp == ACT);
        if (act && !prev_act) begin
            periods++;
            if (seen_act) gap_log.push_back(gap_ticks);
            seen_act = 1'b1;
        end
        if (!act) begin
            if (bus.ce_cycle) gap_ticks++;
        end else begin
            gap_ticks = 0;
        end
        prev_act = act;
    end

    task automatic expect_sig(input string name, input int sel, input logic [7:0] exp);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        bus.main_wr      = 1'b0;
        bus.snd_rd       = 1'b0;
        bus.snd_wr       = 1'b0;
        bus.main_rd      = 1'b0;
        bus.main_ovf_clr = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        bus.main_wr  = 1'b1;
        bus.main_din = b;
        step();
    endtask

    task automatic pop(input logic [7:0] exp);
        exp_pop_q.push_back(exp);
        bus.snd_rd = 1'b1;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_active(input string name);
        for (int i = 0; i < 40; i++) begin
            if (bus.intp == ACT) return;
            step();
        end
        fail_now(name);
    endtask

    initial begin
        int n0;
        int p0;
        vectors      = 0;
        miscompares  = 0;
        periods      = 0;
        gap_ticks    = 0;
        prev_act     = 1'b0;
        seen_act     = 1'b0;
        reset        = 1'b1;
        bus.main_din = 8'h00;
        bus.snd_din  = 8'h00;
        step();
        step();
        reset = 1'b0;
        expect_sig("rst_count", SelCount, 8'd0);
        expect_sig("rst_cmd",   SelCmd,   8'hFF);
        expect_sig("rst_full",  SelFull,  8'd0);
        expect_sig("rst_ovf",   SelOvf,   8'd0);
        expect_sig("rst_reply", SelReply, 8'h00);
        expect_sig("rst_irq",   SelIrq,   8'd0);
        expect_sig("rst_intp",  SelIntp,  8'(IRQ_ACTLOW));
        step();

        // 1: single command, intp active two clks after the strobe
        push(8'h30);
        expect_sig("t1_count", SelCount, 8'd1);
        expect_sig("t1_cmd",   SelCmd,   8'h30);
        expect_sig("t1_intp_early", SelIntp, 8'(IRQ_ACTLOW));
        step();
        expect_sig("t1_intp_act", SelIntp, 8'(ACT));
        pop(8'h30);
        expect_sig("t1_count_pop", SelCount, 8'd0);
        expect_sig("t1_intp_off",  SelIntp,  8'(IRQ_ACTLOW));
        idle(20);
        expect_sig("t1_intp_quiet", SelIntp, 8'(IRQ_ACTLOW));
        step();

        // 2: three commands, one intp period each
        n0 = gap_log.size();
        p0 = periods;
        push(8'h30);
        push(8'h31);
        push(8'h32);
        for (int i = 0; i < 3; i++) begin
            wait_active("t2_wait_intp");
            pop(8'(8'h30 + i));
        end
        expect_sig("t2_cmd_empty", SelCmd,   8'hFF);
        expect_sig("t2_count",     SelCount, 8'd0);
        idle(20);
        check("t2_periods", 8'(periods - p0), 8'd3);
        if (gap_log.size() < n0 + 3) begin
            fail_now("t2_gap_log");
        end else begin
            for (int i = 1; i < 3; i++) begin
                check("t2_gap_ok", 8'(gap_log[n0 + i] >= int'(IRQ_GAP)), 8'd1);
            end
        end

        // 3: overflow, set-wins, clear, push+pop while full
        for (int i = 0; i < 4; i++) push(8'(8'h40 + i));
        expect_sig("t3_full",     SelFull,  8'd1);
        expect_sig("t3_ovf_pre",  SelOvf,   8'd0);
        push(8'h44);
        expect_sig("t3_ovf",      SelOvf,   8'd1);
        expect_sig("t3_count",    SelCount, 8'd4);
        bus.main_ovf_clr = 1'b1;
        push(8'h46);
        expect_sig("t3_ovf_setwins", SelOvf, 8'd1);
        bus.main_ovf_clr = 1'b1;
        step();
        expect_sig("t3_ovf_clr", SelOvf, 8'd0);
        bus.main_wr  = 1'b1;
        bus.main_din = 8'h45;
        pop(8'h40);
        expect_sig("t3_pp_count", SelCount, 8'd4);
        expect_sig("t3_pp_full",  SelFull,  8'd1);
        expect_sig("t3_pp_ovf",   SelOvf,   8'd0);
        pop(8'h41);
        expect_sig("t3_notfull", SelFull, 8'd0);
        pop(8'h42);
        pop(8'h43);
        pop(8'h45);
        expect_sig("t3_drained", SelCount, 8'd0);
        idle(20);

        // 4: push+pop on empty, pop on empty
        bus.main_wr  = 1'b1;
        bus.main_din = 8'hA5;
        pop(8'hFF);
        expect_sig("t4_count", SelCount, 8'd1);
        expect_sig("t4_cmd",   SelCmd,   8'hA5);
        pop(8'hA5);
        pop(8'hFF);
        expect_sig("t4_empty_count", SelCount, 8'd0);
        expect_sig("t4_empty_cmd",   SelCmd,   8'hFF);
        expect_sig("t4_empty_ovf",   SelOvf,   8'd0);
        idle(20);

        // 5: reply latch
        bus.snd_wr  = 1'b1;
        bus.snd_din = 8'h5A;
        step();
        expect_sig("t5_reply", SelReply, 8'h5A);
        expect_sig("t5_irq",   SelIrq,   8'd1);
        bus.main_rd = 1'b1;
        step();
        expect_sig("t5_irq_clr",  SelIrq,   8'd0);
        expect_sig("t5_reply_kp", SelReply, 8'h5A);
        bus.snd_wr  = 1'b1;
        bus.snd_din = 8'h11;
        bus.main_rd = 1'b1;
        step();
        expect_sig("t5_wr_wins_irq",   SelIrq,   8'd1);
        expect_sig("t5_wr_wins_reply", SelReply, 8'h11);

        // 6: reset while in the gap with two commands still queued
        push(8'h50);
        push(8'h51);
        push(8'h52);
        wait_active("t6_wait_intp");
        pop(8'h50);
        step();
        expect_sig("t6_gap_intp", SelIntp, 8'(IRQ_ACTLOW));
        reset = 1'b1;
        step();
        reset = 1'b0;
        expect_sig("t6_count", SelCount, 8'd0);
        expect_sig("t6_cmd",   SelCmd,   8'hFF);
        expect_sig("t6_intp",  SelIntp,  8'(IRQ_ACTLOW));
        expect_sig("t6_irq",   SelIrq,   8'd0);
        expect_sig("t6_reply", SelReply, 8'h00);
        p0 = periods;
        idle(30);
        check("t6_no_intp", 8'(periods - p0), 8'd0);
        expect_sig("t6_intp_end", SelIntp, 8'(IRQ_ACTLOW));
        step();
        step();
        if (exp_pop_q.size() != 0) fail_now("pop_leftover");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
